mlp_seq_regressor: RTL and testbench
====================================

# mlp_seq_regressor

Time-multiplexed, parametrised successor to the fully combinational printed-MLP regressor cores. It evaluates a one-hidden-layer ReLU MLP (N_IN unsigned features, N_HID hidden neurons, one regression output) using a single shared multiply-accumulate unit, trading latency for area. Weights and biases are elaboration-time constants, and the block sits between the sensor/feature front end and the downstream consumer, with valid/ready handshakes on both sides.

## Interface
- N_IN, 4, number of input features
- IN_W, 4, feature width in bits (unsigned)
- N_HID, 3, number of hidden neurons
- W_W, 8, signed weight width
- B_W, 16, signed bias width
- ACC_W, 20, signed accumulator width
- ACT_W, 11, hidden activation width (unsigned)
- OUT_W, 18, output width (unsigned)
- SAT, 1, ReLU overflow mode: 1 clamps to all-ones, 0 truncates to low bits
- W0, N_HID*N_IN*W_W packed, hidden weights; neuron h, input i at [(h*N_IN+i)*W_W +: W_W]; default {64,64,-64,-64},{72,72,-73,-72},{-23,-23,28,24}
- B0, N_HID*B_W packed, hidden biases; default {-7,-298,75}
- W1, N_HID*W_W packed, output weights; default {-76,68,-8}
- B1, B_W packed, output bias; default 19666

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  feature vector valid
- in_ready  out  1  block can accept a vector
- in_data  in  N_IN*IN_W  feature i at [i*IN_W +: IN_W]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  ReLU'd regression output
- busy  out  1  computation in progress (L0 or L1)

## Operation
- FSM states: IDLE, L0, L1, DONE.
- IDLE: in_ready=1. On in_valid, capture in_data into the feature register, load acc with sign-extended B0[0], clear indices, and go to L0. in_data is don't-care after acceptance.
- L0: one MAC per cycle, acc += signed(W0[h][i]) * {0,x_i}, with i iterating fastest and h from 0 to N_HID-1. On the last input of neuron h, write act[h] = ReLU(acc+product):
  - negative gives 0;
  - if the value exceeds 2^ACT_W-1, SAT=1 gives 2^ACT_W-1 and SAT=0 gives the low ACT_W bits.
  - acc is then reloaded with B0[h+1], or with B1 after the last neuron, and the FSM goes to L1.
- L1: one MAC per cycle, acc += signed(W1[h]) * {0,act[h]}. On the last term, out_data = ReLU(sum) with the same SAT rule at OUT_W bits, out_valid=1, and the FSM goes to DONE.
- DONE: hold out_data and out_valid until out_ready. On out_valid&&out_ready, clear out_valid and go to IDLE. out_data keeps its value.
- Arithmetic is signed at ACC_W bits. ACC_W must cover the full sum; no internal wrap is permitted.
- busy=1 only in L0 and L1.

## Timing
- Acceptance edge: the edge with IDLE && in_valid.
- out_valid rises N_HID*(N_IN+1) edges after the acceptance edge. Default is 15.
- in_ready is a registered-state decode: 1 only in IDLE. There is no acceptance in L0, L1 or DONE.
- out_valid held with out_ready low: out_data stable, no new acceptance.
- out_ready high on the cycle out_valid rises: the result transfers, and IDLE follows on the next edge. Minimum initiation interval is N_HID*(N_IN+1)+2 cycles.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, acc=0, act=0.
- rst in any state aborts the computation at that edge. No output is produced for the aborted vector.
- out_ready while out_valid=0: ignored.

## Test plan
- Defaults, in_data=16'h0000 -> out_data=19066 exactly 15 cycles after acceptance; act={0,0,75}.
- Defaults, features x0=x1=15, x2=x3=0 (in_data=16'h00FF) -> act={1913,1862,0}, out_data=894.
- Defaults, x0=x1=0, x2=x3=15 (in_data=16'hFF00) -> act={0,0,855}, out_data=12826.
- W0 row 0 = {127,127,127,127}, B0[0]=0, all features 15 -> SAT=1 gives act[0]=2047; SAT=0 gives act[0]=1476.
- Backpressure: out_ready low for 10 cycles after out_valid -> out_data stable, in_ready=0, second in_valid not accepted. Accepted once out_ready pulses, with the next result correct.
- Reset mid-L0 (cycle 5 after acceptance) -> next edge: IDLE, in_ready=1, out_valid=0, out_data=0. A following vector computes correctly.

Source files
------------

// File: rtl/mlp_seq_regressor_if.sv
// Stream interface for the sequential MLP regressor: feature vector in, result out.
// Latency: none, wires only.
// Backpressure: valid/ready on both sides; master drives in_*/out_ready, slave drives the rest.
interface mlp_seq_regressor_if #(
  parameter int IN_BITS = 16,
  parameter int OUT_W   = 18
);
  logic               in_valid;
  logic               in_ready;
  logic [IN_BITS-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [OUT_W-1:0]   out_data;
  logic               busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/mlp_seq_regressor.sv
// One-hidden-layer ReLU MLP regressor evaluated on a single shared MAC.
// Latency: out_valid rises N_HID*(N_IN+1) edges after the acceptance edge.
// Backpressure: accepts only when idle; result is held until out_ready, then returns to idle.
module mlp_seq_regressor #(
  parameter int N_IN  = 4,
  parameter int IN_W  = 4,
  parameter int N_HID = 3,
  parameter int W_W   = 8,
  parameter int B_W   = 16,
  parameter int ACC_W = 20,
  parameter int ACT_W = 11,
  parameter int OUT_W = 18,
  parameter bit SAT   = 1'b1,
  parameter logic [N_HID*N_IN*W_W-1:0] W0 = 96'h181CE9E9_B8B74848_C0C04040,
  parameter logic [N_HID*B_W-1:0]      B0 = 48'h004B_FED6_FFF9,
  parameter logic [N_HID*W_W-1:0]      W1 = 24'hF844B4,
  parameter logic [B_W-1:0]            B1 = 16'h4CD2
) (
  input  logic clk,
  input  logic rst,
  mlp_seq_regressor_if.slave io
);

  localparam int HW = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic signed [ACC_W-1:0] ACT_MAX = ACC_W'((64'd1 << ACT_W) - 64'd1);
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);

  typedef enum logic [1:0] {IDLE, L0, L1, DONE} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [N_IN*IN_W-1:0]     feat;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  w_ext;
  logic signed [ACC_W-1:0]  x_ext;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  b_nxt;
  logic [ACT_W-1:0]         act [N_HID];
  logic [ACT_W-1:0]         act_cur;
  logic [ACT_W-1:0]         act_relu;
  logic [OUT_W-1:0]         out_relu;
  logic [OUT_W-1:0]         out_q;
  logic [HW-1:0]            h_idx;
  logic [IW-1:0]            i_idx;
  logic                     h_last;
  logic                     i_last;
  int                       b_idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nxt    = state;
    io.in_ready  = 1'b0;
    io.busy      = 1'b0;
    io.out_valid = 1'b0;
    case (state)
      IDLE: begin
        io.in_ready = 1'b1;
        if (io.in_valid) state_nxt = L0;
      end
      L0: begin
        io.busy = 1'b1;
        if (i_last && h_last) state_nxt = L1;
      end
      L1: begin
        io.busy = 1'b1;
        if (h_last) state_nxt = DONE;
      end
      DONE: begin
        io.out_valid = 1'b1;
        if (io.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign io.out_data = out_q;

  // Shared MAC operand selection, accumulation, next bias and ReLU clamps
  always_comb begin
    h_last  = (int'(h_idx) == N_HID - 1);
    i_last  = (int'(i_idx) == N_IN - 1);
    act_cur = act[h_idx];
    w_ext   = '0;
    x_ext   = '0;
    if (state == L1) begin
      w_ext = ACC_W'($signed(W1[int'(h_idx)*W_W +: W_W]));
      x_ext = ACC_W'(act_cur);
    end else begin
      w_ext = ACC_W'($signed(W0[(int'(h_idx)*N_IN + int'(i_idx))*W_W +: W_W]));
      x_ext = ACC_W'(feat[int'(i_idx)*IN_W +: IN_W]);
    end
    prod  = w_ext * x_ext;
    sum   = acc + prod;
    // Guard the index so the final neuron never selects past the bias vector
    b_idx = h_last ? 0 : int'(h_idx) + 1;
    b_nxt = h_last ? ACC_W'($signed(B1)) : ACC_W'($signed(B0[b_idx*B_W +: B_W]));
    if (sum < 0)             act_relu = '0;
    else if (sum > ACT_MAX)  act_relu = SAT ? '1 : sum[ACT_W-1:0];
    else                     act_relu = sum[ACT_W-1:0];
    if (sum < 0)             out_relu = '0;
    else if (sum > OUT_MAX)  out_relu = SAT ? '1 : sum[OUT_W-1:0];
    else                     out_relu = sum[OUT_W-1:0];
  end

  // Datapath: feature capture, accumulator, activations, indices and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      feat  <= '0;
      acc   <= '0;
      h_idx <= '0;
      i_idx <= '0;
      out_q <= '0;
      for (int k = 0; k < N_HID; k++) act[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io.in_valid) begin
            feat  <= io.in_data;
            acc   <= ACC_W'($signed(B0[B_W-1:0]));
            h_idx <= '0;
            i_idx <= '0;
          end
        end
        L0: begin
          if (i_last) begin
            act[h_idx] <= act_relu;
            acc        <= b_nxt;
            i_idx      <= '0;
            h_idx      <= h_last ? '0 : h_idx + 1'b1;
          end else begin
            acc   <= sum;
            i_idx <= i_idx + 1'b1;
          end
        end
        L1: begin
          acc <= sum;
          if (h_last) begin
            out_q <= out_relu;
            h_idx <= '0;
          end else begin
            h_idx <= h_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_seq_regressor.sv
// Directed bench for mlp_seq_regressor: default weights plus two saturation variants.
// Latency: checks the fixed N_HID*(N_IN+1) result latency.
// Backpressure: holds out_ready low with a pending vector and checks nothing slips through.
module tb_mlp_seq_regressor;

  localparam logic [95:0] W0_DEF = 96'h181CE9E9_B8B74848_C0C04040;
  localparam logic [47:0] B0_DEF = 48'h004B_FED6_FFF9;
  localparam logic [23:0] W1_DEF = 24'hF844B4;
  localparam logic [15:0] B1_DEF = 16'h4CD2;
  localparam logic [95:0] W0_SAT = 96'h181CE9E9_B8B74848_7F7F7F7F;
  localparam logic [47:0] B0_SAT = 48'h004B_FED6_0000;
  localparam int LAT = 15;

  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  mlp_seq_regressor_if #(.IN_BITS(16), .OUT_W(18)) bus ();
  mlp_seq_regressor_if #(.IN_BITS(16), .OUT_W(18)) bs1 ();
  mlp_seq_regressor_if #(.IN_BITS(16), .OUT_W(18)) bs0 ();

  assign bs1.in_valid  = bus.in_valid;
  assign bs1.in_data   = bus.in_data;
  assign bs1.out_ready = bus.out_ready;
  assign bs0.in_valid  = bus.in_valid;
  assign bs0.in_data   = bus.in_data;
  assign bs0.out_ready = bus.out_ready;

  mlp_seq_regressor dut (.clk(clk), .rst(rst), .io(bus));
  mlp_seq_regressor #(.SAT(1'b1), .W0(W0_SAT), .B0(B0_SAT)) dut_s1 (.clk(clk), .rst(rst), .io(bs1));
  mlp_seq_regressor #(.SAT(1'b0), .W0(W0_SAT), .B0(B0_SAT)) dut_s0 (.clk(clk), .rst(rst), .io(bs0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input longint actual, input longint expected);
    n_cmp++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, actual, expected);
    end
  endtask

  function automatic int relu(input int v, input int maxv, input bit sat);
    if (v < 0) return 0;
    if (v > maxv) return sat ? maxv : (v & maxv);
    return v;
  endfunction

  // Plain-arithmetic evaluation of the network for one feature vector
  function automatic int model_out(input logic [95:0] w0, input logic [47:0] b0,
                                   input logic [23:0] w1, input logic [15:0] b1,
                                   input bit sat, input logic [15:0] x);
    int a;
    int s;
    int hact;
    s = int'($signed(b1));
    for (int h = 0; h < 3; h++) begin
      a = int'($signed(b0[h*16 +: 16]));
      for (int i = 0; i < 4; i++)
        a += int'($signed(w0[(h*4+i)*8 +: 8])) * int'(x[i*4 +: 4]);
      hact = relu(a, 2047, sat);
      s += int'($signed(w1[h*8 +: 8])) * hact;
    end
    return relu(s, 262143, sat);
  endfunction

  // Transaction-level model: cycles remaining, result-held flag, held results
  bit m_live = 1'b0;
  int m_cnt  = 0;
  bit m_ov   = 1'b0;
  int m_od  [3];
  int pend  [3];

  always @(posedge clk) begin
    if (rst) begin
      m_live = 1'b1;
      m_cnt  = 0;
      m_ov   = 1'b0;
      for (int k = 0; k < 3; k++) m_od[k] = 0;
    end else if (m_live) begin
      if (m_cnt == 0 && !m_ov) begin
        if (bus.in_valid) begin
          m_cnt   = LAT;
          pend[0] = model_out(W0_DEF, B0_DEF, W1_DEF, B1_DEF, 1'b1, bus.in_data);
          pend[1] = model_out(W0_SAT, B0_SAT, W1_DEF, B1_DEF, 1'b1, bus.in_data);
          pend[2] = model_out(W0_SAT, B0_SAT, W1_DEF, B1_DEF, 1'b0, bus.in_data);
        end
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_ov = 1'b1;
          for (int k = 0; k < 3; k++) m_od[k] = pend[k];
        end
      end else if (bus.out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (m_live) begin
      check("in_ready",     bus.in_ready,  longint'(m_cnt == 0 && !m_ov));
      check("busy",         bus.busy,      longint'(m_cnt > 0));
      check("out_valid",    bus.out_valid, longint'(m_ov));
      check("out_data",     bus.out_data,  m_od[0]);
      check("s1_out_valid", bs1.out_valid, longint'(m_ov));
      check("s1_out_data",  bs1.out_data,  m_od[1]);
      check("s0_out_valid", bs0.out_valid, longint'(m_ov));
      check("s0_out_data",  bs0.out_data,  m_od[2]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ov(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input logic [15:0] d, input int exp_out,
                         input int e0, input int e1, input int e2);
    int lat;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 16'hA5A5;
    wait_ov(lat);
    check("latency", lat, LAT);
    check("result",  bus.out_data, exp_out);
    check("act0", dut.act[0], e0);
    check("act1", dut.act[1], e1);
    check("act2", dut.act[2], e2);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) tick();
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_busy",      bus.busy,      0);
    rst = 1'b0;
    tick();

    run_vec(16'h0000, 19066, 0, 0, 75);
    run_vec(16'h00FF, 894, 1913, 1862, 0);
    run_vec(16'hFF00, 12826, 0, 0, 855);
    run_vec(16'hFFFF, 18346, 0, 0, 165);
    check("sat1_act0", dut_s1.act[0], 2047);
    check("sat0_act0", dut_s0.act[0], 1476);
    check("sat1_out",  bs1.out_data, 0);
    check("sat0_out",  bs0.out_data, 0);

    // Result held under backpressure while a second vector waits
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h00FF;
    tick();
    bus.in_data  = 16'hFF00;
    wait_ov(lat);
    check("bp_latency", lat, LAT);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_hold_data",  bus.out_data,  894);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_in_ready",   bus.in_ready,  0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp_idle", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    wait_ov(lat);
    check("bp2_latency", lat, LAT);
    check("bp2_result",  bus.out_data, 12826);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // Reset on the fifth edge after acceptance aborts the computation
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h00FF;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("abort_in_ready",  bus.in_ready,  1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_data",  bus.out_data,  0);
    check("abort_busy",      bus.busy,      0);
    rst = 1'b0;
    tick();
    run_vec(16'hFF00, 12826, 0, 0, 855);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
